// File: rtl/data_memory_sync.sv
// Registered-read data memory with a sequential init sweep, address-range
// checking and registered read-valid / error / drop strobes.
module data_memory_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              ClearReq,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    output logic              Busy,
    output logic              AddrErr,
    output logic              ReqDrop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t            state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              addr_err_q;
    logic              req_drop_q;

    logic              in_range;
    logic [PTR_W-1:0]  idx;

    // Lower half ascends from 0; upper half counts down from 0 (two's complement).
    function automatic logic [DATA_W-1:0] init_word(input logic [PTR_W-1:0] i);
        logic [DATA_W-1:0] off;
        if (int'(i) < DEPTH / 2) begin
            return DATA_W'(int'(i));
        end
        off = DATA_W'(int'(i) - DEPTH / 2);
        return -off;
    endfunction

    // Full-width compare so upper address bits never alias onto valid entries.
    assign in_range = ({1'b0, Address} < DEPTH_L);
    assign idx      = Address[PTR_W-1:0];

    // Storage has no reset; the sweep is what restores contents.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == ST_INIT) begin
                mem_q[ptr_q] <= init_word(ptr_q);
            end else if (MemWrite && in_range) begin
                mem_q[idx] <= WriteData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            req_drop_q <= 1'b0;
        end else begin
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            req_drop_q <= 1'b0;
            if (state_q == ST_INIT) begin
                req_drop_q <= MemRead | MemWrite;
                if (ptr_q == LAST) begin
                    state_q <= ST_IDLE;
                    ptr_q   <= '0;
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                end
            end else begin
                // Old word is sampled here, so a same-edge write is read-before-write.
                if (MemRead) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= in_range ? mem_q[idx] : '0;
                end
                addr_err_q <= (MemRead | MemWrite) & ~in_range;
                if (ClearReq) begin
                    state_q <= ST_INIT;
                    ptr_q   <= '0;
                end
            end
        end
    end

    assign ReadData  = rdata_q;
    assign ReadValid = rvalid_q;
    assign Busy      = (state_q == ST_INIT);
    assign AddrErr   = addr_err_q;
    assign ReqDrop   = req_drop_q;

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench for data_memory_sync: default build plus a 16-bit/64-word build.
module tb_data_memory_sync;

    logic       clk = 1'b0;
    logic       reset_n, MemRead, MemWrite, ClearReq;
    logic [7:0] Address, WriteData;
    logic [7:0] ReadData;
    logic       ReadValid, Busy, AddrErr, ReqDrop;

    logic        reset2_n, MemRead2, MemWrite2, ClearReq2;
    logic [7:0]  Address2;
    logic [15:0] WriteData2, ReadData2;
    logic        ReadValid2, Busy2, AddrErr2, ReqDrop2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_memory_sync dut (
        .clk(clk), .reset_n(reset_n), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ClearReq(ClearReq),
        .ReadData(ReadData), .ReadValid(ReadValid), .Busy(Busy),
        .AddrErr(AddrErr), .ReqDrop(ReqDrop)
    );

    data_memory_sync #(.DATA_W(16), .ADDR_W(8), .DEPTH(64)) dut2 (
        .clk(clk), .reset_n(reset2_n), .Address(Address2), .WriteData(WriteData2),
        .MemRead(MemRead2), .MemWrite(MemWrite2), .ClearReq(ClearReq2),
        .ReadData(ReadData2), .ReadValid(ReadValid2), .Busy(Busy2),
        .AddrErr(AddrErr2), .ReqDrop(ReqDrop2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        Address = a; WriteData = d; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        Address = a; MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
        chk({tag, "_valid"}, 32'(ReadValid), 32'd1);
        chk({tag, "_data"}, 32'(ReadData), 32'(exp));
    endtask

    task automatic rd2(input string tag, input logic [7:0] a, input logic [15:0] exp);
        Address2 = a; MemRead2 = 1'b1;
        tick();
        MemRead2 = 1'b0;
        chk({tag, "_valid"}, 32'(ReadValid2), 32'd1);
        chk({tag, "_data"}, 32'(ReadData2), 32'(exp));
    endtask

    // Count edges until Busy falls, bounded so a stuck sweep still ends the run.
    task automatic sweep_len(output int n);
        n = 0;
        while (Busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [7:0] pat8(input int i);
        if (i < 16) return 8'(i);
        return 8'(256 - (i - 16));
    endfunction

    initial begin
        int n;
        int drops;
        int vlds;
        reset_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ClearReq = 1'b0;
        Address = '0; WriteData = '0;
        reset2_n = 1'b0; MemRead2 = 1'b0; MemWrite2 = 1'b0; ClearReq2 = 1'b0;
        Address2 = '0; WriteData2 = '0;

        repeat (3) tick();
        chk("rst_busy", 32'(Busy), 32'd1);
        chk("rst_rdata", 32'(ReadData), 32'd0);
        chk("rst_rvalid", 32'(ReadValid), 32'd0);
        chk("rst_addrerr", 32'(AddrErr), 32'd0);
        chk("rst_reqdrop", 32'(ReqDrop), 32'd0);
        reset_n = 1'b1;
        reset2_n = 1'b1;

        sweep_len(n);
        chk("sweep_len", 32'(n), 32'd32);

        rd("rd0", 8'd0, 8'h00);
        rd("rd5", 8'd5, 8'h05);
        rd("rd15", 8'd15, 8'h0F);
        rd("rd16", 8'd16, 8'h00);
        rd("rd17", 8'd17, 8'hFF);
        rd("rd31", 8'd31, 8'hF1);
        tick();
        chk("idle_rvalid", 32'(ReadValid), 32'd0);
        chk("idle_hold", 32'(ReadData), 32'hF1);

        // Read-before-write on the same address.
        wr(8'd3, 8'hA5);
        Address = 8'd3; WriteData = 8'h3C; MemRead = 1'b1; MemWrite = 1'b1;
        tick();
        MemRead = 1'b0; MemWrite = 1'b0;
        chk("rbw_old", 32'(ReadData), 32'hA5);
        rd("rbw_new", 8'd3, 8'h3C);

        // Out-of-range writes and reads.
        wr(8'd32, 8'h77);
        chk("oor_wr_err", 32'(AddrErr), 32'd1);
        tick();
        chk("oor_err_pulse", 32'(AddrErr), 32'd0);
        rd("oor_rd", 8'd32, 8'h00);
        chk("oor_rd_err", 32'(AddrErr), 32'd1);
        rd("noalias0", 8'd0, 8'h00);
        chk("inrange_err", 32'(AddrErr), 32'd0);
        wr(8'd35, 8'h66);
        rd("noalias3", 8'd3, 8'h3C);
        rd("oor_hi", 8'hE3, 8'h00);

        // Clear: requests during the sweep are dropped.
        wr(8'd20, 8'h55);
        rd("pre_clr20", 8'd20, 8'h55);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        chk("clr_busy", 32'(Busy), 32'd1);
        drops = 0; vlds = 0;
        Address = 8'd20; MemRead = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (ReqDrop) drops++;
            if (ReadValid) vlds++;
        end
        MemRead = 1'b0;
        chk("clr_drops", 32'(drops), 32'd32);
        chk("clr_novalid", 32'(vlds), 32'd0);
        chk("clr_done", 32'(Busy), 32'd0);
        rd("clr20", 8'd20, 8'hFC);
        chk("clr_nodrop", 32'(ReqDrop), 32'd0);

        // Reset in the middle of a sweep restarts it from entry 0.
        wr(8'd2, 8'h99);
        wr(8'd25, 8'h99);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        repeat (9) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_busy", 32'(Busy), 32'd1);
        sweep_len(n);
        chk("mid_sweep_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rd($sformatf("pat%0d", i), 8'(i), pat8(i));
        end

        // Wide build.
        n = 0;
        while (Busy2 && n < 200) begin
            tick();
            n++;
        end
        chk("w_busy", 32'(Busy2), 32'd0);
        rd2("w33", 8'd33, 16'hFFFF);
        rd2("w31", 8'd31, 16'd31);
        rd2("w63", 8'd63, 16'hFFE1);
        rd2("w64", 8'd64, 16'h0000);
        chk("w64_err", 32'(AddrErr2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
